// File: rtl/vga_timing_pkg.sv
// Shared 800x600 @ 60 Hz (40 MHz pixel clock) timing constants for the snake VGA path.
// Every screen control module compares against these values, so they live in one place.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int H_SYNC   = 128;
    localparam int H_BACK   = 88;
    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 40;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int H_START  = H_SYNC + H_BACK;

    localparam int V_SYNC   = 4;
    localparam int V_BACK   = 23;
    localparam int V_ACTIVE = 600;
    localparam int V_FRONT  = 1;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int V_START  = V_SYNC + V_BACK;

    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/snake_vga_sync_module_if.sv
// Sync and pixel-address bundle handed from the timing generator to the screen control modules.
interface snake_vga_sync_module_if;
    import vga_timing_pkg::*;

    logic   HSYNC_Sig;
    logic   VSYNC_Sig;
    logic   Ready_Sig;
    count_t Column_Addr_Sig;
    count_t Row_Addr_Sig;
    logic   Frame_Start_Sig;

    modport master (
        output HSYNC_Sig, VSYNC_Sig, Ready_Sig,
        output Column_Addr_Sig, Row_Addr_Sig, Frame_Start_Sig
    );

    modport slave (
        input HSYNC_Sig, VSYNC_Sig, Ready_Sig,
        input Column_Addr_Sig, Row_Addr_Sig, Frame_Start_Sig
    );

endinterface

// File: rtl/vga_wrap_counter.sv
// Free-running modulo counter: counts 0..MAX while inc_en is high and flags the wrap clock.
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = H_TOTAL - 1
) (
    input  logic   CLK,
    input  logic   RSTn,
    input  logic   inc_en,
    output count_t count,
    output logic   wrap
);

    localparam count_t MAX_C = count_t'(MAX);

    assign wrap = inc_en && (count == MAX_C);

    // Advance on inc_en and fold back to zero on the clock after the terminal value.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (inc_en) begin
            count <= count + count_t'(1);
        end
    end

endmodule

// File: rtl/snake_vga_sync_module.sv
// VGA timing generator: horizontal/vertical counters plus registered sync, ready,
// pixel-address and frame-start outputs. All outputs sit one clock behind the counters.
module snake_vga_sync_module
    import vga_timing_pkg::count_t;
#(
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BACK   = vga_timing_pkg::H_BACK,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BACK   = vga_timing_pkg::V_BACK,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_timing_pkg::V_FRONT
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    snake_vga_sync_module_if.master        vga
);

    localparam int H_TOTAL_L = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL_L = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam count_t H_SYNC_C  = count_t'(H_SYNC);
    localparam count_t H_START_C = count_t'(H_SYNC + H_BACK);
    localparam count_t H_END_C   = count_t'(H_SYNC + H_BACK + H_ACTIVE);
    localparam count_t V_SYNC_C  = count_t'(V_SYNC);
    localparam count_t V_START_C = count_t'(V_SYNC + V_BACK);
    localparam count_t V_END_C   = count_t'(V_SYNC + V_BACK + V_ACTIVE);

    count_t count_h;
    count_t count_v;
    logic   h_wrap;
    logic   v_wrap_unused;
    logic   h_visible;
    logic   v_visible;

    // The line counter runs every clock; its wrap steps the frame counter by one line.
    vga_wrap_counter #(.MAX(H_TOTAL_L - 1)) u_count_h (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .inc_en (1'b1),
        .count  (count_h),
        .wrap   (h_wrap)
    );

    vga_wrap_counter #(.MAX(V_TOTAL_L - 1)) u_count_v (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .inc_en (h_wrap),
        .count  (count_v),
        .wrap   (v_wrap_unused)
    );

    assign h_visible = (count_h >= H_START_C) && (count_h < H_END_C);
    assign v_visible = (count_v >= V_START_C) && (count_v < V_END_C);

    // Register every output from the same counter snapshot so they stay mutually aligned;
    // addresses are only formed inside the visible window and are zero elsewhere.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vga.HSYNC_Sig       <= 1'b1;
            vga.VSYNC_Sig       <= 1'b1;
            vga.Ready_Sig       <= 1'b0;
            vga.Column_Addr_Sig <= '0;
            vga.Row_Addr_Sig    <= '0;
            vga.Frame_Start_Sig <= 1'b0;
        end else begin
            vga.HSYNC_Sig       <= !(count_h < H_SYNC_C);
            vga.VSYNC_Sig       <= !(count_v < V_SYNC_C);
            vga.Ready_Sig       <= h_visible && v_visible;
            vga.Column_Addr_Sig <= (h_visible && v_visible) ? (count_h - H_START_C) : '0;
            vga.Row_Addr_Sig    <= (h_visible && v_visible) ? (count_v - V_START_C) : '0;
            vga.Frame_Start_Sig <= (count_h == '0) && (count_v == '0);
        end
    end

endmodule

// File: doc/snake_vga_sync_module.md
# snake_vga_sync_module

Timing generator for the snake VGA path: produces 800x600 @ 60 Hz (40 MHz pixel clock) horizontal/vertical sync and the `Ready_Sig` / `Column_Addr_Sig` / `Row_Addr_Sig` triple that every screen control module (game, win, lose) consumes. It sits directly upstream of those control modules and drives the VGA connector sync pins.

## Interface
Parameters:
- H_SYNC, 128, hsync pulse width (clocks)
- H_BACK, 88, horizontal back porch
- H_ACTIVE, 800, visible columns
- H_FRONT, 40, horizontal front porch (H_TOTAL = 1056)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch
- V_ACTIVE, 600, visible rows
- V_FRONT, 1, vertical front porch (V_TOTAL = 628)

Ports:
- CLK  in  1  40 MHz pixel clock
- RSTn  in  1  reset, asynchronous, active-low
- HSYNC_Sig  out  1  horizontal sync, active-low
- VSYNC_Sig  out  1  vertical sync, active-low
- Ready_Sig  out  1  high while the current pixel is in the visible area
- Column_Addr_Sig  out  11  visible column 0..H_ACTIVE-1; 0 when not ready
- Row_Addr_Sig  out  11  visible row 0..V_ACTIVE-1; 0 when not ready
- Frame_Start_Sig  out  1  one-clock pulse at the start of each frame

## Operation
- Internal counters Count_H (11 bit, 0..H_TOTAL-1) and Count_V (11 bit, 0..V_TOTAL-1).
- Count_H increments every clock and wraps to 0 after H_TOTAL-1.
- Count_V increments only on the clock where Count_H wraps. It wraps to 0 after V_TOTAL-1 on that same clock.
- H_START = H_SYNC+H_BACK (216); V_START = V_SYNC+V_BACK (27).
- All outputs are registers computed from the current (Count_H, Count_V):
  - HSYNC_Sig = 0 iff Count_H < H_SYNC.
  - VSYNC_Sig = 0 iff Count_V < V_SYNC.
  - Ready_Sig = 1 iff H_START ≤ Count_H < H_START+H_ACTIVE and V_START ≤ Count_V < V_START+V_ACTIVE.
  - Column_Addr_Sig = Count_H−H_START and Row_Addr_Sig = Count_V−V_START when ready; both 0 otherwise. Subtraction is 11-bit unsigned and is never evaluated outside the window.
  - Frame_Start_Sig = 1 iff Count_H==0 and Count_V==0.
- No state machine beyond the two counters; the block free-runs with no enable or stall.

## Timing
- Reset values: Count_H=0, Count_V=0, HSYNC_Sig=1, VSYNC_Sig=1, Ready_Sig=0, Column_Addr_Sig=0, Row_Addr_Sig=0, Frame_Start_Sig=0.
- Latency: all outputs lag the counters by exactly one clock and are mutually aligned (same pipeline stage).
- First clock edge after RSTn deasserts:
  - Frame_Start_Sig=1, HSYNC_Sig=0, VSYNC_Sig=0.
  - Counters advance to (1,0).
- Line period 1056 clocks; frame period 1056×628 = 663168 clocks.
- Frame_Start_Sig period equals the frame period, width 1 clock.
- Ready_Sig is high for 800 consecutive clocks per visible line, on 600 lines per frame; 480000 ready clocks per frame.
- Counter wraps:
  - At Count_H=1055 the next state is Count_H=0 and Count_V+1.
  - At (1055,627) the next state is (0,0).
  - There are no skipped or duplicated counts.
- Asynchronous RSTn mid-line forces all reset values immediately. Counting restarts from (0,0) on release.
- Downstream consumers register the addresses once more (ROM fetch), so the sync outputs must be delayed by those consumers if pixel alignment is needed. This block does not compensate for downstream latency.

## Structure
- The eight timing constants and the derived H_TOTAL, V_TOTAL, H_START and V_START belong in a shared package `vga_timing_pkg`, so that all screen control modules compare against the same values.
- One sub-module is natural: `vga_wrap_counter` (parameter MAX, with inc_en input, count and wrap outputs). It is instantiated twice; the horizontal wrap output drives the vertical inc_en.

## Test plan
- Reset held 10 clocks, then released → Frame_Start_Sig=1 on the first edge. HSYNC_Sig is low for 128 clocks, then high.
- Across one line, count clocks → Ready_Sig rises at output clock 217 after line start (Count_H=216 plus 1 latency). Column_Addr_Sig runs 0..799 with no gaps, then returns to 0 with Ready_Sig=0.
- Run a full frame → VSYNC_Sig is low for exactly 4×1056 clocks. Row_Addr_Sig runs 0..599. The next Frame_Start_Sig arrives 663168 clocks after the first.
- At position (1055,627) → the next clock shows Frame_Start_Sig=1 and both addresses 0. There is no line 628.
- Assert RSTn mid-visible area (Count_H=500, Count_V=300) → outputs go to reset values asynchronously, before the next edge. After release, the timing matches the first scenario.
- Check invariant every clock → Ready_Sig=0 whenever HSYNC_Sig=0 or VSYNC_Sig=0; addresses are 0 whenever Ready_Sig=0.
